// File: rtl/pong_pkg.sv
// Shared encodings for the Pong match sequencer: FSM states, winner codes and serve directions.
// Pure declarations; no logic, no latency, no flow control.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-low 7-segment pattern (bit order gfedcba); non-digits blank.
// Combinational, zero latency; no flow control.
module seg7_decode (
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'b1111111;
    case (digit)
      4'd0: seg_n = 7'b1000000;
      4'd1: seg_n = 7'b1111001;
      4'd2: seg_n = 7'b0100100;
      4'd3: seg_n = 7'b0110000;
      4'd4: seg_n = 7'b0011001;
      4'd5: seg_n = 7'b0010010;
      4'd6: seg_n = 7'b0000010;
      4'd7: seg_n = 7'b1111000;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0010000;
      default: seg_n = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/match_sequencer.sv
// Pong match controller: idle/serve/play/pause/point/game-over FSM with scores; optional hex digits via MATCH_SEQ_HEX_EN.
// All outputs registered, one clk after the causing sample; no backpressure, pulses act in the cycle they arrive.
module match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               logic_run,
  output logic               serve_req,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner,
  output logic [2:0]         state
`ifdef MATCH_SEQ_HEX_EN
  ,
  output logic [6:0]         hex_left,
  output logic [6:0]         hex_right
`endif
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             start_low_q;
  logic             start_rise;

  // Remembering "start was low" rather than the last start value means a start
  // held high across reset release never looks like an edge.
  assign start_rise = start & start_low_q;
  assign state      = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      logic_run   <= 1'b0;
      serve_req   <= 1'b0;
      serve_dir   <= SERVE_RIGHT;
      score_left  <= '0;
      score_right <= '0;
      winner      <= WIN_NONE;
      cnt         <= '0;
      start_low_q <= 1'b0;
    end else begin
      start_low_q <= ~start;
      serve_req   <= 1'b0;
      case (st)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_rise) begin
            score_left  <= '0;
            score_right <= '0;
            winner      <= WIN_NONE;
            serve_dir   <= SERVE_RIGHT;
            cnt         <= SERVE_LOAD;
            st          <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (cnt == CNT_ONE) begin
              st        <= ST_PLAY;
              logic_run <= 1'b1;
              serve_req <= 1'b1;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        ST_PLAY: begin
          if (miss_left || miss_right) begin
            st        <= ST_POINT;
            logic_run <= 1'b0;
            cnt       <= POINT_LOAD;
            // A simultaneous double miss is a dead ball: no score, serve side kept.
            if (miss_left && !miss_right) begin
              score_right <= (score_right == WIN) ? WIN : score_right + SCORE_ONE;
              serve_dir   <= SERVE_LEFT;
            end else if (miss_right && !miss_left) begin
              score_left <= (score_left == WIN) ? WIN : score_left + SCORE_ONE;
              serve_dir  <= SERVE_RIGHT;
            end
          end else if (pause) begin
            st        <= ST_PAUSED;
            logic_run <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            st        <= ST_PLAY;
            logic_run <= 1'b1;
          end
        end
        ST_POINT: begin
          if (frame_tick) begin
            if (cnt == CNT_ONE) begin
              if (score_left == WIN) begin
                st     <= ST_GAME_OVER;
                winner <= WIN_LEFT;
              end else if (score_right == WIN) begin
                st     <= ST_GAME_OVER;
                winner <= WIN_RIGHT;
              end else begin
                st  <= ST_SERVE;
                cnt <= SERVE_LOAD;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        default: begin
          st        <= ST_IDLE;
          logic_run <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATCH_SEQ_HEX_EN
  logic [6:0] seg_left_n;
  logic [6:0] seg_right_n;

  seg7_decode u_seg_left (
    .digit (4'(score_left % SCORE_W'(10))),
    .seg_n (seg_left_n)
  );

  seg7_decode u_seg_right (
    .digit (4'(score_right % SCORE_W'(10))),
    .seg_n (seg_right_n)
  );

  assign hex_left  = (st == ST_IDLE) ? 7'b1111111 : seg_left_n;
  assign hex_right = (st == ST_IDLE) ? 7'b1111111 : seg_right_n;
`endif

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed match walk-through plus random play, checked every cycle against a rule-level model.
module tb_match_sequencer;

  localparam int WIN = 7;
  localparam int SF  = 60;
  localparam int PF  = 90;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, start, pause, miss_left, miss_right;
  logic       logic_run, serve_req, serve_dir;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;
  logic [2:0] state;
`ifdef MATCH_SEQ_HEX_EN
  logic [6:0] hex_left, hex_right;
`endif

  match_sequencer #(.WIN_SCORE(WIN), .SCORE_W(4), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .start       (start),
    .pause       (pause),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .logic_run   (logic_run),
    .serve_req   (serve_req),
    .serve_dir   (serve_dir),
    .score_left  (score_left),
    .score_right (score_right),
    .winner      (winner),
    .state       (state)
`ifdef MATCH_SEQ_HEX_EN
    ,
    .hex_left    (hex_left),
    .hex_right   (hex_right)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase uses the published state codes; frames are counted up since phase entry.
  int m_phase, m_frames, m_sl, m_sr, m_win, m_dir, m_req, m_run;
  bit m_start_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_frames = 0; m_sl = 0; m_sr = 0; m_win = 0;
    m_dir = 1; m_req = 0; m_run = 0; m_start_low = 0;
  endtask

  task automatic model_step();
    bit rise;
    rise = start && m_start_low;
    m_start_low = !start;
    m_req = 0;
    case (m_phase)
      0, 5: if (rise) begin
        m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1; m_frames = 0; m_phase = 1;
      end
      1: if (frame_tick) begin
        m_frames++;
        if (m_frames == SF) begin m_phase = 2; m_req = 1; end
      end
      2: if (miss_left || miss_right) begin
        if (miss_left && !miss_right) begin
          m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_dir = 0;
        end else if (miss_right && !miss_left) begin
          m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_dir = 1;
        end
        m_phase = 4; m_frames = 0;
      end else if (pause) m_phase = 3;
      3: if (!pause) m_phase = 2;
      4: if (frame_tick) begin
        m_frames++;
        if (m_frames == PF) begin
          if (m_sl == WIN) begin m_phase = 5; m_win = 1; end
          else if (m_sr == WIN) begin m_phase = 5; m_win = 2; end
          else begin m_phase = 1; m_frames = 0; end
        end
      end
      default: m_phase = 0;
    endcase
    m_run = (m_phase == 2) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_phase);
    chk("logic_run", 32'(logic_run), m_run);
    chk("serve_req", 32'(serve_req), m_req);
    chk("serve_dir", 32'(serve_dir), m_dir);
    chk("score_left", 32'(score_left), m_sl);
    chk("score_right", 32'(score_right), m_sr);
    chk("winner", 32'(winner), m_win);
    chk("req_without_run", 32'(serve_req & ~logic_run), 0);
  endtask

  // One clock: DUT samples at the edge, model follows the same sample, outputs checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
    check_all();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  task automatic wait_serve(input int budget);
    bit found;
    int i;
    found = 0;
    i = 0;
    while (!found && i < budget) begin
      frame_tick = (i % 2 == 0);
      tick();
      if (serve_req === 1'b1) found = 1;
      i++;
    end
    frame_tick = 1'b0;
    chk("serve_wait", 32'(found), 1);
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; pause = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_dir", 32'(serve_dir), 1);
    chk("rst_run", 32'(logic_run), 0);
    rst_n = 1'b1; tick();

    // First serve: exactly 60 frame ticks, serve_req one cycle after the last.
    start = 1'b1; tick();
    chk("start_to_serve", 32'(state), 1);
    start = 1'b0; tick();
    pulses(SF - 1);
    chk("serve_not_early", 32'(state), 1);
    frame_tick = 1'b1; tick();
    chk("serve_req_pulse", 32'(serve_req), 1);
    chk("play_run", 32'(logic_run), 1);
    chk("play_scores", 32'({score_left, score_right}), 0);
    frame_tick = 1'b0; tick();
    chk("serve_req_one_cycle", 32'(serve_req), 0);

    // Left miss: right scores, serve toward left, freeze then new serve.
    miss_left = 1'b1; tick(); miss_left = 1'b0;
    chk("miss_score_right", 32'(score_right), 1);
    chk("miss_dir", 32'(serve_dir), 0);
    chk("miss_run_low", 32'(logic_run), 0);
    pulses(PF - 1);
    chk("point_not_early", 32'(state), 4);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    chk("point_to_serve", 32'(state), 1);
    wait_serve(4 * SF);

    // Double miss: no score change, serve side kept.
    miss_left = 1'b1; miss_right = 1'b1; tick();
    miss_left = 1'b0; miss_right = 1'b0;
    chk("double_state", 32'(state), 4);
    chk("double_scores", 32'({score_left, score_right}), 32'h01);
    chk("double_dir", 32'(serve_dir), 0);
    wait_serve(4 * (SF + PF));

    // Pause: misses ignored, resume without serve.
    pause = 1'b1; tick();
    chk("paused_state", 32'(state), 3);
    miss_left = 1'b1; tick(); miss_left = 1'b0; tick();
    chk("paused_miss_ignored", 32'(score_right), 1);
    pause = 1'b0; tick();
    chk("resume_state", 32'(state), 2);
    chk("resume_no_serve", 32'(serve_req), 0);

    // Left wins 7-1.
    for (int p = 0; p < WIN; p++) begin
      miss_right = 1'b1; tick(); miss_right = 1'b0;
      if (p < WIN - 1) wait_serve(4 * (SF + PF));
    end
    chk("left_seven", 32'(score_left), 7);
    pulses(PF);
    chk("game_over", 32'(state), 5);
    chk("winner_left", 32'(winner), 1);
    miss_left = 1'b1; tick(); miss_left = 1'b0;
    chk("go_miss_ignored", 32'(score_right), 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_state", 32'(state), 1);
    chk("restart_scores", 32'({score_left, score_right}), 0);
    chk("restart_winner", 32'(winner), 0);

    // Reset in POINT with start held high through release.
    wait_serve(4 * SF);
    miss_left = 1'b1; tick(); miss_left = 1'b0;
    start = 1'b1; tick();
    #2 rst_n = 1'b0;
    #1 model_reset(); check_all();
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_score", 32'(score_right), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    pulses(10);
    chk("held_start_no_edge", 32'(state), 0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("fresh_start", 32'(state), 1);
    start = 1'b0;

    // Random play.
    for (int c = 0; c < 30000; c++) begin
      frame_tick = ($urandom % 3 == 0);
      miss_left  = ($urandom % 40 == 0);
      miss_right = ($urandom % 40 == 0);
      if ($urandom % 150 == 0) pause = ~pause;
      if ($urandom % 60 == 0) start = ~start;
      rst_n = ($urandom % 8000 != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
